// File: rtl/gpu_bg_block_cache.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_bg_block_cache
//  Purpose  : Single-block background pixel cache with one-entry write-back
//             buffer; GPU_BG_SAVE_FORWARD_EN forwards a pending save on reopen.
//  Revision : 1.0 - initial release
// ============================================================================
module gpu_bg_block_cache #(
    parameter int LANES     = 2,
    parameter int BLOCK_PIX = 16,
    parameter int ADR_W     = 15,
    localparam int SLOT_W   = (BLOCK_PIX / LANES > 1) ? $clog2(BLOCK_PIX / LANES) : 1
) (
    input  logic                    clk,
    input  logic                    i_nrst,
    input  logic                    i_pixValid,
    input  logic [ADR_W-1:0]        i_pixAdr,
    input  logic [SLOT_W-1:0]       i_pixSlot,
    input  logic [LANES-1:0]        i_pixLaneEn,
    input  logic [16*LANES-1:0]     i_pixData,
    input  logic                    i_needBG,
    input  logic                    i_flush,
    output logic                    o_pixReady,
    output logic [16*LANES-1:0]     o_bgRead,
    output logic                    o_loadReq,
    output logic [ADR_W-1:0]        o_loadAdr,
    input  logic                    i_loadAck,
    input  logic [16*BLOCK_PIX-1:0] i_loadData,
    output logic                    o_saveReq,
    output logic [ADR_W-1:0]        o_saveAdr,
    output logic [16*BLOCK_PIX-1:0] o_saveData,
    output logic [BLOCK_PIX-1:0]    o_saveMsk,
    input  logic                    i_saveAck,
    output logic                    o_busy
);

    localparam int c_GROUPS = BLOCK_PIX / LANES;
    localparam int c_BEAT_W = 16 * LANES;
    localparam int c_BLK_W  = 16 * BLOCK_PIX;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_BLK_W-1:0]   r_actData;
    logic [BLOCK_PIX-1:0] r_actMsk;
    logic [ADR_W-1:0]     r_actAdr;
    logic [c_BLK_W-1:0]   r_savData;
    logic [BLOCK_PIX-1:0] r_savMsk;
    logic [ADR_W-1:0]     r_savAdr;
    logic                 r_savFull;
    logic                 r_flushPend;

    logic                 w_isActive;
    logic                 w_hit;
    logic                 w_dirty;
    logic                 w_bufFree;
    logic                 w_hazard;
    logic                 w_miss;
    logic                 w_open;
    logic                 w_flushAct;
    logic                 w_flushGo;
    int                   w_slot;
    logic [c_BLK_W-1:0]   w_wrData;
    logic [BLOCK_PIX-1:0] w_wrMsk;

    assign w_isActive = (r_state == ST_ACTIVE);
    assign w_hit      = (i_pixAdr == r_actAdr);
    assign o_pixReady = i_pixValid && w_isActive && w_hit && !i_flush;

    // Block contents including this cycle's accepted beat, so an eviction on
    // the same edge as a write never drops the written pixels.
    always_comb begin
        w_slot   = (c_GROUPS > 1) ? int'(i_pixSlot) : 0;
        w_wrData = r_actData;
        w_wrMsk  = r_actMsk;
        if (o_pixReady) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_pixLaneEn[l]) begin
                    w_wrData[(w_slot * LANES + l) * 16 +: 16] = i_pixData[l * 16 +: 16];
                    w_wrMsk[w_slot * LANES + l]               = 1'b1;
                end
            end
        end
    end

    assign w_dirty    = |w_wrMsk;
    assign w_bufFree  = !r_savFull || i_saveAck;
    assign w_hazard   = r_savFull && !i_saveAck && (r_savAdr == i_pixAdr);
    assign w_miss     = i_pixValid && !i_flush && !r_flushPend &&
                        ((r_state == ST_EMPTY) || (w_isActive && !w_hit));
`ifdef GPU_BG_SAVE_FORWARD_EN
    assign w_open     = w_miss && (!(w_isActive && w_dirty) || w_bufFree);
`else
    assign w_open     = w_miss && (!(w_isActive && w_dirty) || w_bufFree) && !w_hazard;
`endif
    assign w_flushAct = w_isActive && (i_flush || r_flushPend);
    assign w_flushGo  = w_flushAct && (!w_dirty || w_bufFree);

    assign o_bgRead   = r_actData[w_slot * c_BEAT_W +: c_BEAT_W];
    assign o_loadReq  = (r_state == ST_LOADING);
    assign o_loadAdr  = r_actAdr;
    assign o_saveReq  = r_savFull;
    assign o_saveAdr  = r_savAdr;
    assign o_saveData = r_savData;
    assign o_saveMsk  = r_savMsk;
    assign o_busy     = (r_state == ST_LOADING) || r_savFull;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= ST_EMPTY;
            r_actData   <= '0;
            r_actMsk    <= '0;
            r_actAdr    <= '0;
            r_savData   <= '0;
            r_savMsk    <= '0;
            r_savAdr    <= '0;
            r_savFull   <= 1'b0;
            r_flushPend <= 1'b0;
        end else begin
            r_actData <= w_wrData;
            r_actMsk  <= w_wrMsk;
            if (r_savFull && i_saveAck) begin
                r_savFull <= 1'b0;
            end
            case (r_state)
                ST_LOADING: begin
                    if (i_flush) begin
                        r_flushPend <= 1'b1;
                    end
                    if (i_loadAck) begin
                        r_actData <= i_loadData;
                        r_actMsk  <= '0;
                        r_state   <= ST_ACTIVE;
                    end
                end
                default: begin
                    if (w_flushGo) begin
                        if (w_dirty) begin
                            r_savData <= w_wrData;
                            r_savMsk  <= w_wrMsk;
                            r_savAdr  <= r_actAdr;
                            r_savFull <= 1'b1;
                        end
                        r_flushPend <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else if (w_flushAct) begin
                        // Dirty flush blocked by a full buffer: retry each cycle.
                        r_flushPend <= 1'b1;
                    end else if (w_open) begin
                        if (w_isActive && w_dirty) begin
                            r_savData <= w_wrData;
                            r_savMsk  <= w_wrMsk;
                            r_savAdr  <= r_actAdr;
                            r_savFull <= 1'b1;
                        end
                        r_actAdr <= i_pixAdr;
                        r_actMsk <= '0;
`ifdef GPU_BG_SAVE_FORWARD_EN
                        if (w_hazard) begin
                            r_actData <= r_savData;
                            r_actMsk  <= r_savMsk;
                            r_state   <= ST_ACTIVE;
                        end else
`endif
                        if (i_needBG) begin
                            r_state <= ST_LOADING;
                        end else begin
                            r_actData <= '0;
                            r_state   <= ST_ACTIVE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_bg_block_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_bg_block_cache
//  Purpose  : Directed self-checking bench for gpu_bg_block_cache (default
//             parameters); expectations follow GPU_BG_SAVE_FORWARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_bg_block_cache;

    logic          clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_pixValid = 1'b0;
    logic [14:0]   i_pixAdr = '0;
    logic [2:0]    i_pixSlot = '0;
    logic [1:0]    i_pixLaneEn = '0;
    logic [31:0]   i_pixData = '0;
    logic          i_needBG = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_pixReady;
    logic [31:0]   o_bgRead;
    logic          o_loadReq;
    logic [14:0]   o_loadAdr;
    logic          i_loadAck = 1'b0;
    logic [255:0]  i_loadData = '0;
    logic          o_saveReq;
    logic [14:0]   o_saveAdr;
    logic [255:0]  o_saveData;
    logic [15:0]   o_saveMsk;
    logic          i_saveAck = 1'b0;
    logic          o_busy;

    int tests = 0;
    int fails = 0;

    gpu_bg_block_cache dut (
        .clk        (clk),
        .i_nrst     (i_nrst),
        .i_pixValid (i_pixValid),
        .i_pixAdr   (i_pixAdr),
        .i_pixSlot  (i_pixSlot),
        .i_pixLaneEn(i_pixLaneEn),
        .i_pixData  (i_pixData),
        .i_needBG   (i_needBG),
        .i_flush    (i_flush),
        .o_pixReady (o_pixReady),
        .o_bgRead   (o_bgRead),
        .o_loadReq  (o_loadReq),
        .o_loadAdr  (o_loadAdr),
        .i_loadAck  (i_loadAck),
        .i_loadData (i_loadData),
        .o_saveReq  (o_saveReq),
        .o_saveAdr  (o_saveAdr),
        .o_saveData (o_saveData),
        .o_saveMsk  (o_saveMsk),
        .i_saveAck  (i_saveAck),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0010;
        repeat (2) tick();
        tests++; if (o_pixReady !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0h want 0", o_pixReady); end
        tests++; if (o_loadReq !== 1'b0) begin fails++; $display("FAIL reset_loadReq: got %0h want 0", o_loadReq); end
        tests++; if (o_saveReq !== 1'b0) begin fails++; $display("FAIL reset_saveReq: got %0h want 0", o_saveReq); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h want 0", o_busy); end
        tests++; if (o_saveMsk !== 16'h0) begin fails++; $display("FAIL reset_saveMsk: got %0h want 0", o_saveMsk); end
        tests++; if (o_bgRead !== 32'h0) begin fails++; $display("FAIL reset_bgRead: got %0h want 0", o_bgRead); end
        i_pixValid = 1'b0;
        i_nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic_write();
        i_needBG = 1'b0;
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0010;
        i_pixSlot = 3'd3;
        i_pixLaneEn = 2'b11;
        i_pixData = 32'h7FFF_001F;
        #1;
        tests++; if (o_pixReady !== 1'b0) begin fails++; $display("FAIL basic_ready_c1: got %0h want 0", o_pixReady); end
        tick();
        tests++; if (o_pixReady !== 1'b1) begin fails++; $display("FAIL basic_ready_c2: got %0h want 1", o_pixReady); end
        tests++; if (o_bgRead !== 32'h0) begin fails++; $display("FAIL basic_prewrite: got %0h want 0", o_bgRead); end
        tick();
        i_pixValid = 1'b0;
        #1;
        tests++; if (o_bgRead !== 32'h7FFF_001F) begin fails++; $display("FAIL basic_readback: got %0h want 7fff001f", o_bgRead); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tests++; if (o_saveReq !== 1'b1) begin fails++; $display("FAIL basic_saveReq: got %0h want 1", o_saveReq); end
        tests++; if (o_saveAdr !== 15'h0010) begin fails++; $display("FAIL basic_saveAdr: got %0h want 10", o_saveAdr); end
        tests++; if (o_saveMsk !== 16'h00C0) begin fails++; $display("FAIL basic_saveMsk: got %0h want c0", o_saveMsk); end
        tests++; if (o_saveData[127:96] !== 32'h7FFF_001F) begin fails++; $display("FAIL basic_saveData: got %0h want 7fff001f", o_saveData[127:96]); end
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %0h want 1", o_busy); end
        i_saveAck = 1'b1;
        tick();
        i_saveAck = 1'b0;
        tests++; if (o_saveReq !== 1'b0) begin fails++; $display("FAIL basic_saveAck: got %0h want 0", o_saveReq); end
    endtask

    task automatic test_load();
        i_needBG = 1'b1;
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0020;
        i_pixSlot = 3'd0;
        i_pixLaneEn = 2'b00;
        #1;
        tests++; if (o_loadReq !== 1'b0) begin fails++; $display("FAIL load_idle: got %0h want 0", o_loadReq); end
        tick();
        tests++; if (o_loadReq !== 1'b1) begin fails++; $display("FAIL load_req: got %0h want 1", o_loadReq); end
        tests++; if (o_loadAdr !== 15'h0020) begin fails++; $display("FAIL load_adr: got %0h want 20", o_loadAdr); end
        tests++; if (o_pixReady !== 1'b0) begin fails++; $display("FAIL load_ready: got %0h want 0", o_pixReady); end
        tick();
        tests++; if (o_loadReq !== 1'b1 || o_busy !== 1'b1) begin fails++; $display("FAIL load_hold: got req %0h busy %0h want 1 1", o_loadReq, o_busy); end
        i_loadAck = 1'b1;
        i_loadData = {16{16'h1234}};
        tick();
        i_loadAck = 1'b0;
        tests++; if (o_loadReq !== 1'b0) begin fails++; $display("FAIL load_done: got %0h want 0", o_loadReq); end
        tests++; if (o_pixReady !== 1'b1) begin fails++; $display("FAIL load_active: got %0h want 1", o_pixReady); end
        tests++; if (o_bgRead !== 32'h1234_1234) begin fails++; $display("FAIL load_bgRead: got %0h want 12341234", o_bgRead); end
        i_pixLaneEn = 2'b01;
        i_pixData = 32'h0000_ABCD;
        tick();
        i_pixValid = 1'b0;
        #1;
        tests++; if (o_bgRead !== 32'h1234_ABCD) begin fails++; $display("FAIL load_merge: got %0h want 1234abcd", o_bgRead); end
    endtask

    task automatic test_stall();
        i_needBG = 1'b0;
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0010;
        i_pixSlot = 3'd0;
        i_pixLaneEn = 2'b11;
        i_pixData = 32'h1111_2222;
        #1;
        tests++; if (o_pixReady !== 1'b0) begin fails++; $display("FAIL stall_miss: got %0h want 0", o_pixReady); end
        tick();
        tests++; if (o_saveReq !== 1'b1 || o_saveAdr !== 15'h0020) begin fails++; $display("FAIL stall_evict: got req %0h adr %0h want 1 20", o_saveReq, o_saveAdr); end
        tests++; if (o_saveMsk !== 16'h0001 || o_saveData[15:0] !== 16'hABCD) begin fails++; $display("FAIL stall_evictData: got msk %0h d %0h want 1 abcd", o_saveMsk, o_saveData[15:0]); end
        tests++; if (o_pixReady !== 1'b1) begin fails++; $display("FAIL stall_open: got %0h want 1", o_pixReady); end
        tick();
        i_pixAdr = 15'h0011;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (o_pixReady !== 1'b0) begin fails++; $display("FAIL stall_hold%0d: got %0h want 0", i, o_pixReady); end
            tick();
        end
        tests++; if (o_saveAdr !== 15'h0020) begin fails++; $display("FAIL stall_bufKeep: got %0h want 20", o_saveAdr); end
        i_saveAck = 1'b1;
        tick();
        i_saveAck = 1'b0;
        tests++; if (o_saveReq !== 1'b1 || o_saveAdr !== 15'h0010) begin fails++; $display("FAIL stall_refill: got req %0h adr %0h want 1 10", o_saveReq, o_saveAdr); end
        tests++; if (o_saveMsk !== 16'h0003 || o_saveData[31:0] !== 32'h1111_2222) begin fails++; $display("FAIL stall_refillData: got msk %0h d %0h want 3 11112222", o_saveMsk, o_saveData[31:0]); end
        tests++; if (o_pixReady !== 1'b1) begin fails++; $display("FAIL stall_newBlk: got %0h want 1", o_pixReady); end
        i_pixValid = 1'b0;
        #1;
    endtask

    task automatic test_hazard();
        i_saveAck = 1'b1;
        tick();
        i_saveAck = 1'b0;
        i_needBG = 1'b0;
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0030;
        i_pixSlot = 3'd1;
        i_pixLaneEn = 2'b01;
        i_pixData = 32'h0000_5555;
        tick();
        tests++; if (o_saveReq !== 1'b0 || o_pixReady !== 1'b1) begin fails++; $display("FAIL hazard_cleanOpen: got save %0h rdy %0h want 0 1", o_saveReq, o_pixReady); end
        tick();
        i_pixValid = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tests++; if (o_saveAdr !== 15'h0030 || o_saveMsk !== 16'h0004) begin fails++; $display("FAIL hazard_save: got adr %0h msk %0h want 30 4", o_saveAdr, o_saveMsk); end
        i_pixValid = 1'b1;
        i_needBG = 1'b1;
        i_pixLaneEn = 2'b00;
        #1;
`ifdef GPU_BG_SAVE_FORWARD_EN
        tick();
        tests++; if (o_pixReady !== 1'b1 || o_loadReq !== 1'b0) begin fails++; $display("FAIL hazard_fwd: got rdy %0h load %0h want 1 0", o_pixReady, o_loadReq); end
        tests++; if (o_bgRead !== 32'h0000_5555) begin fails++; $display("FAIL hazard_fwdData: got %0h want 00005555", o_bgRead); end
        tests++; if (o_saveReq !== 1'b1) begin fails++; $display("FAIL hazard_fwdSave: got %0h want 1", o_saveReq); end
        i_saveAck = 1'b1;
        tick();
        i_saveAck = 1'b0;
`else
        for (int i = 0; i < 3; i++) begin
            tests++; if (o_loadReq !== 1'b0) begin fails++; $display("FAIL hazard_wait%0d: got %0h want 0", i, o_loadReq); end
            tick();
        end
        i_saveAck = 1'b1;
        tick();
        i_saveAck = 1'b0;
        tests++; if (o_loadReq !== 1'b1 || o_loadAdr !== 15'h0030) begin fails++; $display("FAIL hazard_load: got req %0h adr %0h want 1 30", o_loadReq, o_loadAdr); end
        i_loadAck = 1'b1;
        i_loadData = '0;
        tick();
        i_loadAck = 1'b0;
        tests++; if (o_pixReady !== 1'b1 || o_bgRead !== 32'h0) begin fails++; $display("FAIL hazard_loaded: got rdy %0h d %0h want 1 0", o_pixReady, o_bgRead); end
`endif
        tests++; if (o_saveReq !== 1'b0) begin fails++; $display("FAIL hazard_saveDone: got %0h want 0", o_saveReq); end
    endtask

    task automatic test_flush_priority();
        logic [15:0] expMsk;
`ifdef GPU_BG_SAVE_FORWARD_EN
        expMsk = 16'h0024;
`else
        expMsk = 16'h0020;
`endif
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0030;
        i_pixSlot = 3'd2;
        i_pixLaneEn = 2'b10;
        i_pixData = 32'h6666_0000;
        tick();
        i_flush = 1'b1;
        i_pixSlot = 3'd0;
        i_pixLaneEn = 2'b11;
        i_pixData = 32'hDEAD_BEEF;
        #1;
        tests++; if (o_pixReady !== 1'b0) begin fails++; $display("FAIL flush_prio: got %0h want 0", o_pixReady); end
        tick();
        i_flush = 1'b0;
        i_pixValid = 1'b0;
        tests++; if (o_saveReq !== 1'b1 || o_saveAdr !== 15'h0030) begin fails++; $display("FAIL flush_save: got req %0h adr %0h want 1 30", o_saveReq, o_saveAdr); end
        tests++; if (o_saveMsk !== expMsk) begin fails++; $display("FAIL flush_mask: got %0h want %0h", o_saveMsk, expMsk); end
        tests++; if (o_saveData[15:0] !== 16'h0 || o_saveData[95:80] !== 16'h6666) begin fails++; $display("FAIL flush_data: got p0 %0h p5 %0h want 0 6666", o_saveData[15:0], o_saveData[95:80]); end
        i_saveAck = 1'b1;
        tick();
        i_saveAck = 1'b0;
    endtask

    task automatic test_reset_loading();
        i_needBG = 1'b1;
        i_pixValid = 1'b1;
        i_pixAdr = 15'h0040;
        tick();
        tests++; if (o_loadReq !== 1'b1 || o_loadAdr !== 15'h0040) begin fails++; $display("FAIL rstld_req: got req %0h adr %0h want 1 40", o_loadReq, o_loadAdr); end
        i_pixValid = 1'b0;
        #2;
        i_nrst = 1'b0;
        #1;
        tests++; if (o_loadReq !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rstld_async: got req %0h busy %0h want 0 0", o_loadReq, o_busy); end
        tick();
        i_nrst = 1'b1;
        i_loadAck = 1'b1;
        i_loadData = {16{16'hBEEF}};
        tick();
        i_loadAck = 1'b0;
        tests++; if (o_loadReq !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rstld_lateAck: got req %0h busy %0h want 0 0", o_loadReq, o_busy); end
        tests++; if (o_bgRead !== 32'h0) begin fails++; $display("FAIL rstld_data: got %0h want 0", o_bgRead); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_load();
        test_stall();
        test_hazard();
        test_flush_priority();
        test_reset_loading();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
